// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: signal bundle between the board RX pin, the UART
// receiver and the command/loopback logic that consumes received words.
//   uart_rxd    serial line into the receiver (idles high)
//   uart_done   one-cycle pulse when a frame completes
//   uart_data   last received word, held until the next uart_done
//   parity_err  parity mismatch on the last frame (held)
//   frame_err   a stop bit was sampled low on the last frame (held)
//   busy        receiver is inside a frame
// master: the receiver side. slave: the side that drives the line and
// consumes the words.
interface uart_rx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic                 uart_rxd;
  logic                 uart_done;
  logic [DATA_BITS-1:0] uart_data;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  modport master (
    input  uart_rxd,
    output uart_done,
    output uart_data,
    output parity_err,
    output frame_err,
    output busy
  );

  modport slave (
    output uart_rxd,
    input  uart_done,
    input  uart_data,
    input  parity_err,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: parametrised UART receiver (5..9 data bits, optional
// odd/even parity, one or two stop bits). Each bit is the 3-sample
// majority of rx_s2 around mid-bit; false starts are rejected.
// Ports:
//   sys_clk    rising-edge clock
//   sys_rst_n  asynchronous active-low reset
//   bus        uart_rx_frame_if.master (uart_rxd in; uart_done, uart_data,
//              parity_err, frame_err, busy out, all registered)
module uart_rx_frame #(
  parameter int CLK_FREQ  = 50000000,
  parameter int UART_BPS  = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  uart_rx_frame_if.master bus
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int HALF    = BPS_CNT / 2;
  localparam int CW      = $clog2(BPS_CNT);

  localparam logic [CW-1:0] CNT_LAST = CW'(BPS_CNT - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(HALF);
  localparam logic [CW-1:0] CNT_DEC  = CW'(HALF + 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  // Majority of three samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Parity bit the transmitter should have sent for this data word.
  function automatic logic par_expect(input logic [DATA_BITS-1:0] d);
    if (PARITY == 1) begin
      return ~(^d);
    end else begin
      return ^d;
    end
  endfunction

  state_t state;
  state_t next_state;

  logic                 rx_s1;
  logic                 rx_s2;
  logic                 rx_s3;
  logic [CW-1:0]        clk_cnt;
  logic [3:0]           bit_cnt;
  logic                 smp_a;
  logic                 smp_b;
  logic                 vote;
  logic                 decide;
  logic                 bit_end;
  logic                 fin_pend;
  logic [DATA_BITS-1:0] data_sh;
  logic                 par_flag;
  logic                 frm_flag;

  logic                 done;
  logic [DATA_BITS-1:0] word;
  logic                 perr;
  logic                 ferr;
  logic                 busy;

  // The third vote sample is always the live rx_s2 in the decision cycle.
  assign vote    = maj3(smp_a, smp_b, rx_s2);
  assign decide  = (state != IDLE) && (clk_cnt == CNT_DEC);
  assign bit_end = (state != IDLE) && (clk_cnt == CNT_LAST);

  // Three-flop synchroniser for the asynchronous serial line.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= bus.uart_rxd;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  // FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic. The last stop bit leaves at its HALF sample so
  // that its decision cycle already runs in IDLE (see fin_pend).
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (rx_s3 && !rx_s2) begin
          next_state = START;
        end else begin
          next_state = IDLE;
        end
      end
      START: begin
        if (decide && vote) begin
          next_state = IDLE;
        end else if (bit_end) begin
          next_state = DATA;
        end else begin
          next_state = START;
        end
      end
      DATA: begin
        if (bit_end && (bit_cnt == DATA_LAST)) begin
          next_state = (PARITY != 0) ? PAR : STOP;
        end else begin
          next_state = DATA;
        end
      end
      PAR: begin
        if (bit_end) begin
          next_state = STOP;
        end else begin
          next_state = PAR;
        end
      end
      STOP: begin
        if ((clk_cnt == CNT_MID) && (bit_cnt == STOP_LAST)) begin
          next_state = IDLE;
        end else begin
          next_state = STOP;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Bit timer: zero in IDLE and on any exit to IDLE, else 0..BPS_CNT-1.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      clk_cnt <= '0;
    end else if ((state == IDLE) || (next_state == IDLE)) begin
      clk_cnt <= '0;
    end else if (clk_cnt == CNT_LAST) begin
      clk_cnt <= '0;
    end else begin
      clk_cnt <= clk_cnt + CW'(1);
    end
  end

  // Bit counter: indexes data bits in DATA and stop bits in STOP.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bit_cnt <= 4'd0;
    end else if ((state == DATA) && bit_end) begin
      bit_cnt <= (bit_cnt == DATA_LAST) ? 4'd0 : bit_cnt + 4'd1;
    end else if ((state == STOP) && bit_end) begin
      bit_cnt <= bit_cnt + 4'd1;
    end else if ((state == IDLE) || (state == START) || (state == PAR)) begin
      bit_cnt <= 4'd0;
    end else begin
      bit_cnt <= bit_cnt;
    end
  end

  // First two vote samples at HALF-1 and HALF.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      smp_a <= 1'b1;
      smp_b <= 1'b1;
    end else if (state != IDLE) begin
      if (clk_cnt == CNT_PRE) begin
        smp_a <= rx_s2;
      end
      if (clk_cnt == CNT_MID) begin
        smp_b <= rx_s2;
      end
    end
  end

  // Data shift register (LSB first) and per-frame error flags.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      data_sh  <= '0;
      par_flag <= 1'b0;
      frm_flag <= 1'b0;
    end else if ((state == IDLE) && (next_state == START)) begin
      par_flag <= 1'b0;
      frm_flag <= 1'b0;
    end else if (decide && (state == DATA)) begin
      data_sh <= {vote, data_sh[DATA_BITS-1:1]};
    end else if (decide && (state == PAR)) begin
      par_flag <= (vote != par_expect(data_sh));
    end else if (decide && (state == STOP)) begin
      frm_flag <= frm_flag | ~vote;
    end
  end

  // Marks the IDLE cycle that carries the final stop-bit decision.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fin_pend <= 1'b0;
    end else begin
      fin_pend <= (state == STOP) && (next_state == IDLE);
    end
  end

  // Registered outputs, all updated together when a frame completes.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      done <= 1'b0;
      word <= '0;
      perr <= 1'b0;
      ferr <= 1'b0;
      busy <= 1'b0;
    end else begin
      done <= fin_pend;
      busy <= (next_state != IDLE);
      if (fin_pend) begin
        word <= data_sh;
        perr <= (PARITY != 0) ? par_flag : 1'b0;
        ferr <= frm_flag | ~vote;
      end
    end
  end

  assign bus.uart_done  = done;
  assign bus.uart_data  = word;
  assign bus.parity_err = perr;
  assign bus.frame_err  = ferr;
  assign bus.busy       = busy;

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed bench for uart_rx_frame.
// dut_a: defaults (8N1, BPS_CNT 434, HALF 217).
// dut_b: 7 data bits, even parity, 2 stop bits, BPS_CNT 32, HALF 16.
module tb_uart_rx_frame;

  localparam int BA = 434;
  localparam int BB = 32;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  int   done_cnt_a = 0;
  int   done_cnt_b = 0;
  int   done_edge_a = 0;
  int   done_edge_b = 0;
  int   busy_rise_a = 0;
  int   busy_fall_a = 0;
  logic busy_prev_a = 1'b0;
  logic [6:0] data_arr_b [16];

  uart_rx_frame_if #(.DATA_BITS(8)) bus_a ();
  uart_rx_frame_if #(.DATA_BITS(7)) bus_b ();

  uart_rx_frame dut_a (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus_a)
  );

  uart_rx_frame #(
    .CLK_FREQ  (50000000),
    .UART_BPS  (1562500),
    .DATA_BITS (7),
    .PARITY    (2),
    .STOP_BITS (2)
  ) dut_b (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after posedge n, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus_a.uart_done === 1'b1) begin
      done_cnt_a  <= done_cnt_a + 1;
      done_edge_a <= cyc;
    end
    if (bus_b.uart_done === 1'b1) begin
      done_cnt_b  <= done_cnt_b + 1;
      done_edge_b <= cyc;
      if (done_cnt_b < 16) data_arr_b[done_cnt_b] <= bus_b.uart_data;
    end
    if (bus_a.busy === 1'b1 && busy_prev_a === 1'b0) busy_rise_a <= cyc;
    if (bus_a.busy === 1'b0 && busy_prev_a === 1'b1) busy_fall_a <= cyc;
    busy_prev_a <= bus_a.busy;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_line(input int line, input logic v);
    if (line == 0) bus_a.uart_rxd = v;
    else           bus_b.uart_rxd = v;
  endtask

  // Call at a falling edge. bits[0] is the start bit. k is the edge at
  // which rx_s1 captures the start bit. Bit gl_idx gets a one-cycle
  // inverted pulse gl_off cycles into the bit.
  task automatic drive_bits(input int line, input logic [15:0] bits, input int n,
                            input int bcnt, input int gl_idx, input int gl_off,
                            output int k);
    k = cyc + 1;
    for (int i = 0; i < n; i++) begin
      set_line(line, bits[i]);
      if (i == gl_idx) begin
        repeat (gl_off) @(negedge clk);
        set_line(line, ~bits[i]);
        @(negedge clk);
        set_line(line, bits[i]);
        repeat (bcnt - gl_off - 1) @(negedge clk);
      end else begin
        repeat (bcnt) @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus_a.uart_rxd = 1'b1;
    bus_b.uart_rxd = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (bus_a.uart_done !== 1'b0) begin errors++; $display("FAIL reset_done_a: got %b want 0", bus_a.uart_done); end
    checks++; if (bus_a.uart_data !== 8'h00) begin errors++; $display("FAIL reset_data_a: got %h want 00", bus_a.uart_data); end
    checks++; if (bus_a.parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr_a: got %b want 0", bus_a.parity_err); end
    checks++; if (bus_a.frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr_a: got %b want 0", bus_a.frame_err); end
    checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_a: got %b want 0", bus_a.busy); end
    checks++; if (bus_b.uart_data !== 7'h00) begin errors++; $display("FAIL reset_data_b: got %h want 00", bus_b.uart_data); end
    checks++; if (bus_b.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_b: got %b want 0", bus_b.busy); end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_8n1_basic;
    int k;
    int d0;
    d0 = done_cnt_a;
    drive_bits(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, BA, -1, 0, k);
    repeat (20) @(negedge clk);
    checks++; if (bus_a.uart_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", bus_a.uart_data); end
    checks++; if (bus_a.parity_err !== 1'b0) begin errors++; $display("FAIL basic_perr: got %b want 0", bus_a.parity_err); end
    checks++; if (bus_a.frame_err !== 1'b0) begin errors++; $display("FAIL basic_ferr: got %b want 0", bus_a.frame_err); end
    checks++; if (done_cnt_a - d0 !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt_a - d0); end
    checks++; if (done_edge_a !== k + 4127) begin errors++; $display("FAIL basic_done_edge: got k+%0d want k+4127", done_edge_a - k); end
    checks++; if (busy_fall_a !== k + 4126) begin errors++; $display("FAIL basic_busy_fall: got k+%0d want k+4126", busy_fall_a - k); end
  endtask

  task automatic test_parity;
    int k;
    int d0;
    d0 = done_cnt_b;
    drive_bits(1, {5'b0, 2'b11, 1'b0, 7'h35, 1'b0}, 11, BB, -1, 0, k);
    repeat (10) @(negedge clk);
    checks++; if (bus_b.uart_data !== 7'h35) begin errors++; $display("FAIL par_ok_data: got %h want 35", bus_b.uart_data); end
    checks++; if (bus_b.parity_err !== 1'b0) begin errors++; $display("FAIL par_ok_perr: got %b want 0", bus_b.parity_err); end
    checks++; if (bus_b.frame_err !== 1'b0) begin errors++; $display("FAIL par_ok_ferr: got %b want 0", bus_b.frame_err); end
    checks++; if (done_edge_b !== k + 340) begin errors++; $display("FAIL par_ok_done_edge: got k+%0d want k+340", done_edge_b - k); end
    checks++; if (done_cnt_b - d0 !== 1) begin errors++; $display("FAIL par_ok_done_count: got %0d want 1", done_cnt_b - d0); end
    d0 = done_cnt_b;
    drive_bits(1, {5'b0, 2'b11, 1'b1, 7'h35, 1'b0}, 11, BB, -1, 0, k);
    repeat (10) @(negedge clk);
    checks++; if (bus_b.uart_data !== 7'h35) begin errors++; $display("FAIL par_bad_data: got %h want 35", bus_b.uart_data); end
    checks++; if (bus_b.parity_err !== 1'b1) begin errors++; $display("FAIL par_bad_perr: got %b want 1", bus_b.parity_err); end
    checks++; if (done_cnt_b - d0 !== 1) begin errors++; $display("FAIL par_bad_done_count: got %0d want 1", done_cnt_b - d0); end
  endtask

  task automatic test_back_to_back;
    int k;
    int d0;
    d0 = done_cnt_b;
    drive_bits(1, {5'b0, 2'b11, 1'b0, 7'h12, 1'b0}, 11, BB, -1, 0, k);
    drive_bits(1, {5'b0, 2'b11, 1'b1, 7'h6B, 1'b0}, 11, BB, -1, 0, k);
    repeat (10) @(negedge clk);
    checks++; if (done_cnt_b - d0 !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt_b - d0); end
    checks++; if (data_arr_b[d0] !== 7'h12) begin errors++; $display("FAIL b2b_first_data: got %h want 12", data_arr_b[d0]); end
    checks++; if (data_arr_b[d0+1] !== 7'h6B) begin errors++; $display("FAIL b2b_second_data: got %h want 6b", data_arr_b[d0+1]); end
    checks++; if (bus_b.parity_err !== 1'b0) begin errors++; $display("FAIL b2b_perr: got %b want 0", bus_b.parity_err); end
    checks++; if (bus_b.frame_err !== 1'b0) begin errors++; $display("FAIL b2b_ferr: got %b want 0", bus_b.frame_err); end
  endtask

  task automatic test_frame_err;
    int k;
    int d0;
    d0 = done_cnt_a;
    drive_bits(0, {6'b0, 1'b0, 8'h3C, 1'b0}, 10, BA, -1, 0, k);
    repeat (5 * BA) @(negedge clk);
    checks++; if (bus_a.frame_err !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b want 1", bus_a.frame_err); end
    checks++; if (bus_a.uart_data !== 8'h3C) begin errors++; $display("FAIL ferr_data: got %h want 3c", bus_a.uart_data); end
    set_line(0, 1'b1);
    repeat (2 * BA) @(negedge clk);
    checks++; if (done_cnt_a - d0 !== 1) begin errors++; $display("FAIL ferr_break_done_count: got %0d want 1", done_cnt_a - d0); end
    drive_bits(0, {6'b0, 1'b1, 8'h81, 1'b0}, 10, BA, -1, 0, k);
    repeat (20) @(negedge clk);
    checks++; if (bus_a.uart_data !== 8'h81) begin errors++; $display("FAIL ferr_clean_data: got %h want 81", bus_a.uart_data); end
    checks++; if (bus_a.frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clean_flag: got %b want 0", bus_a.frame_err); end
    checks++; if (bus_a.parity_err !== 1'b0) begin errors++; $display("FAIL ferr_clean_perr: got %b want 0", bus_a.parity_err); end
  endtask

  task automatic test_false_start;
    int k;
    int d0;
    d0 = done_cnt_a;
    k = cyc + 1;
    set_line(0, 1'b0);
    repeat (100) @(negedge clk);
    set_line(0, 1'b1);
    repeat (600) @(negedge clk);
    checks++; if (done_cnt_a - d0 !== 0) begin errors++; $display("FAIL glitch_done_count: got %0d want 0", done_cnt_a - d0); end
    checks++; if (busy_rise_a !== k + 2) begin errors++; $display("FAIL glitch_busy_rise: got k+%0d want k+2", busy_rise_a - k); end
    checks++; if (busy_fall_a !== k + 221) begin errors++; $display("FAIL glitch_busy_fall: got k+%0d want k+221", busy_fall_a - k); end
    checks++; if (bus_a.uart_data !== 8'h81) begin errors++; $display("FAIL glitch_data_held: got %h want 81", bus_a.uart_data); end
  endtask

  task automatic test_reset_midframe;
    int k;
    int d0;
    logic [15:0] f;
    f = {6'b0, 1'b1, 8'h5A, 1'b0};
    drive_bits(0, f, 5, BA, -1, 0, k);
    set_line(0, f[5]);
    repeat (200) @(negedge clk);
    checks++; if (bus_a.busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b want 1", bus_a.busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", bus_a.busy); end
    checks++; if (bus_a.uart_data !== 8'h00) begin errors++; $display("FAIL rstmid_data_a: got %h want 00", bus_a.uart_data); end
    checks++; if (bus_a.uart_done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b want 0", bus_a.uart_done); end
    checks++; if (bus_b.uart_data !== 7'h00) begin errors++; $display("FAIL rstmid_data_b: got %h want 00", bus_b.uart_data); end
    checks++; if (bus_b.parity_err !== 1'b0) begin errors++; $display("FAIL rstmid_perr_b: got %b want 0", bus_b.parity_err); end
    set_line(0, 1'b1);
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    d0 = done_cnt_a;
    drive_bits(0, f, 10, BA, -1, 0, k);
    repeat (500) @(negedge clk);
    checks++; if (bus_a.uart_data !== 8'h5A) begin errors++; $display("FAIL rstmid_frame_data: got %h want 5a", bus_a.uart_data); end
    checks++; if (done_cnt_a - d0 !== 1) begin errors++; $display("FAIL rstmid_done_count: got %0d want 1", done_cnt_a - d0); end
  endtask

  task automatic test_majority;
    int k;
    int d0;
    d0 = done_cnt_a;
    // Frame bit 4 is data bit 3; the pulse lands only on the HALF sample.
    drive_bits(0, {6'b0, 1'b1, 8'h00, 1'b0}, 10, BA, 4, 218, k);
    repeat (20) @(negedge clk);
    checks++; if (bus_a.uart_data !== 8'h00) begin errors++; $display("FAIL vote_data: got %h want 00", bus_a.uart_data); end
    checks++; if (bus_a.frame_err !== 1'b0) begin errors++; $display("FAIL vote_ferr: got %b want 0", bus_a.frame_err); end
    checks++; if (bus_a.parity_err !== 1'b0) begin errors++; $display("FAIL vote_perr: got %b want 0", bus_a.parity_err); end
    checks++; if (done_cnt_a - d0 !== 1) begin errors++; $display("FAIL vote_done_count: got %0d want 1", done_cnt_a - d0); end
  endtask

  initial begin
    test_reset();
    test_8n1_basic();
    test_parity();
    test_back_to_back();
    test_frame_err();
    test_false_start();
    test_reset_midframe();
    test_majority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
